// File: rtl/i3c_ctrl_pkg.sv
// Shared I3C controller definitions: SDR word geometry, sequencer states and
// the T-bit helper used when loading a data word.
package i3c_ctrl_pkg;

  localparam int unsigned SDR_DATA_W = 8;
  localparam int unsigned SDR_WORD_W = SDR_DATA_W + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } seq_state_t;

  // 9th bit of an SDR word: odd-parity T-bit for I3C, released ACK slot for I2C.
  function automatic logic sdr_tbit(input logic [SDR_DATA_W-1:0] data,
                                    input logic                  tbit_en);
    return tbit_en ? ~^data : 1'b1;
  endfunction

endpackage

// File: rtl/i3c_tx_word_sequencer_ser.sv
// Parallel-load shift-register serializer; q is the LSB, shifted right on enable.
module i3c_tx_word_sequencer_ser #(
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  input  logic [DATA_W-1:0] d,
  output logic              q
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
    end else if (load) begin
      sr <= d;
    end else if (enable) begin
      sr <= {1'b1, sr[DATA_W-1:1]};
    end
  end

  assign q = sr[0];

endmodule

// File: rtl/i3c_tx_word_sequencer.sv
// SDR word transmit sequencer: paces a 9-bit serializer one bit per t_bit+1
// clocks, MSB-first data then T-bit / ACK slot, with back-to-back and abort.
module i3c_tx_word_sequencer
  import i3c_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tbit_en,
  output logic              tx_ready,
  input  logic [CNT_W-1:0]  t_bit,
  input  logic              abort,
  output logic              sda_o,
  output logic              bit_strobe,
  output logic              word_done,
  output logic              busy
);

  localparam int unsigned WORD_W = DATA_W + 1;
  localparam int unsigned BC_W   = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  seq_state_t        state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  t_bit_q, t_bit_d;

  logic              bit_end;
  logic              last_cycle;
  logic              accept;
  logic              ser_load;
  logic              ser_enable;
  logic              ser_q;
  logic [WORD_W-1:0] load_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      t_bit_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      t_bit_q   <= t_bit_d;
    end
  end

  // Data is bit-reversed into the load word so the serializer's LSB-first
  // shift puts the byte MSB on the wire first; the T-bit lands last.
  always_comb begin
    load_word = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_word[i] = tx_data[DATA_W-1-i];
    end
    load_word[WORD_W-1] = sdr_tbit(tx_data, tbit_en);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    t_bit_d    = t_bit_q;
    ser_load   = 1'b0;
    ser_enable = 1'b0;

    bit_end    = (state_q == SHIFT) && (timer_q == '0);
    last_cycle = bit_end && (bit_cnt_q == LAST_BIT);
    tx_ready   = ~abort & ((state_q == IDLE) | last_cycle);
    accept     = tx_valid & tx_ready;

    bit_strobe = bit_end & ~abort;
    word_done  = last_cycle & ~abort;
    busy       = (state_q != IDLE);
    sda_o      = (state_q == SHIFT) ? ser_q : 1'b1;

    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      timer_d   = '0;
    end else if (accept) begin
      // Also taken on the last cycle of a word, giving a gapless reload.
      ser_load  = 1'b1;
      t_bit_d   = t_bit;
      timer_d   = t_bit;
      bit_cnt_d = '0;
      state_d   = SHIFT;
    end else if (state_q == SHIFT) begin
      if (bit_end) begin
        ser_enable = 1'b1;
        if (last_cycle) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          timer_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          timer_d   = t_bit_q;
        end
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  i3c_tx_word_sequencer_ser #(
    .DATA_W(WORD_W)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ser_load),
    .enable (ser_enable),
    .d      (load_word),
    .q      (ser_q)
  );

endmodule
